// File: rtl/idct2_16_2.sv
// idct2_16_2 -- tail stage of the inverse 16-point 1-D transform.
//
// Rebuilds the eight odd partial sums O[j] = sum_k r_k[j] * C[k] one column
// per cycle from the transposed 16-point odd matrix. Each column is recombined
// with the even-path value E[j] by butterfly, rounded, shifted and fitted to
// OUT_W bits. The full 16-sample vector is presented through valid/ready.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        synchronous reset, active-high
//   in_valid   input vector valid
//   in_ready   block can accept a vector (only while idle)
//   C[0:7]     odd coefficients, C[k] is coefficient 2k+1 (signed 16)
//   E[0:7]     even-path reconstructed values (signed 26)
//   out_valid  X holds a complete vector
//   out_ready  downstream accepts X
//   X[0:15]    reconstructed samples (signed OUT_W)
//
// Build option
//   IDCT2_16_2_CLIP_EN  defined: saturate rounded results to OUT_W bits.
//                       undefined: keep the low OUT_W bits (two's-complement wrap).

// Constant multiplier bank: one coefficient times the eight odd-matrix
// magnitudes {90,87,80,70,57,43,25,9}, shift-add only.
module idct2_16_2_cmul (
    input  logic signed [15:0] a,
    output logic signed [25:0] p [0:7]
);
    logic signed [25:0] ax;

    assign ax = {{10{a[15]}}, a};

    assign p[0] = (ax <<< 6) + (ax <<< 4) + (ax <<< 3) + (ax <<< 1); // 90
    assign p[1] = (ax <<< 6) + (ax <<< 4) + (ax <<< 3) - ax;         // 87
    assign p[2] = (ax <<< 6) + (ax <<< 4);                           // 80
    assign p[3] = (ax <<< 6) + (ax <<< 3) - (ax <<< 1);              // 70
    assign p[4] = (ax <<< 6) - (ax <<< 3) + ax;                      // 57
    assign p[5] = (ax <<< 5) + (ax <<< 3) + (ax <<< 1) + ax;         // 43
    assign p[6] = (ax <<< 4) + (ax <<< 3) + ax;                      // 25
    assign p[7] = (ax <<< 3) + ax;                                   // 9
endmodule

module idct2_16_2 #(
    parameter int SHIFT = 7,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [15:0]      C [0:7],
    input  logic signed [25:0]      E [0:7],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] X [0:15]
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_OUT
    } state_t;

    // Odd matrix as magnitude index (into the cmul bank) and sign per
    // (row k, column j). Row k is the forward basis for coefficient 2k+1.
    localparam logic [2:0] IDX [0:7][0:7] = '{
        '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7},
        '{3'd1, 3'd4, 3'd7, 3'd5, 3'd2, 3'd0, 3'd3, 3'd6},
        '{3'd2, 3'd7, 3'd3, 3'd1, 3'd6, 3'd4, 3'd0, 3'd5},
        '{3'd3, 3'd5, 3'd1, 3'd7, 3'd0, 3'd6, 3'd2, 3'd4},
        '{3'd4, 3'd2, 3'd6, 3'd0, 3'd7, 3'd1, 3'd5, 3'd3},
        '{3'd5, 3'd0, 3'd4, 3'd6, 3'd1, 3'd3, 3'd7, 3'd2},
        '{3'd6, 3'd3, 3'd0, 3'd2, 3'd5, 3'd7, 3'd4, 3'd1},
        '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}
    };

    // Bit j set means r_k[j] is negative.
    localparam logic [7:0] NEG [0:7] = '{
        8'b0000_0000,
        8'b1111_1000,
        8'b0001_1100,
        8'b1100_0110,
        8'b0011_0110,
        8'b1001_0010,
        8'b0100_1010,
        8'b1010_1010
    };

    localparam logic signed [27:0] RND   = 28'sd1 <<< (SHIFT - 1);
    localparam logic signed [27:0] X_MAX = (28'sd1 <<< (OUT_W - 1)) - 28'sd1;
    localparam logic signed [27:0] X_MIN = -(28'sd1 <<< (OUT_W - 1));

    state_t                    state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic signed [15:0]        c_q [0:7];
    logic signed [15:0]        c_d [0:7];
    logic signed [25:0]        e_q [0:7];
    logic signed [25:0]        e_d [0:7];
    logic signed [OUT_W-1:0]   x_q [0:15];
    logic signed [OUT_W-1:0]   x_d [0:15];

    // Datapath for the current column cnt_q.
    logic signed [25:0]        term [0:7];
    logic signed [25:0]        o_sum;
    logic signed [25:0]        e_sel;
    logic signed [26:0]        s0, s1;
    logic signed [27:0]        r0, r1;
    logic signed [27:0]        sh0, sh1;
    logic signed [OUT_W-1:0]   xa, xb;

    // One signed term r_k[cnt]*C[k] per coefficient.
    for (genvar k = 0; k < 8; k++) begin : g_col
        logic signed [25:0] pk [0:7];
        logic signed [25:0] sel;

        idct2_16_2_cmul u_cmul (
            .a (c_q[k]),
            .p (pk)
        );

        assign sel     = pk[IDX[k][cnt_q]];
        assign term[k] = NEG[k][cnt_q] ? -sel : sel;
    end

    always_comb begin
        o_sum = '0;
        for (int k = 0; k < 8; k++) begin
            o_sum = o_sum + term[k];
        end

        e_sel = e_q[cnt_q];
        // Inputs bounded so that |E +/- O| < 2^26; 27 bits is exact.
        s0 = {e_sel[25], e_sel} + {o_sum[25], o_sum};
        s1 = {e_sel[25], e_sel} - {o_sum[25], o_sum};
        // One extra bit so the rounding offset cannot overflow.
        r0 = {s0[26], s0} + RND;
        r1 = {s1[26], s1} + RND;
        // Arithmetic shift: ties round toward +inf.
        sh0 = r0 >>> SHIFT;
        sh1 = r1 >>> SHIFT;

`ifdef IDCT2_16_2_CLIP_EN
        if (sh0 > X_MAX)      xa = X_MAX[OUT_W-1:0];
        else if (sh0 < X_MIN) xa = X_MIN[OUT_W-1:0];
        else                  xa = sh0[OUT_W-1:0];

        if (sh1 > X_MAX)      xb = X_MAX[OUT_W-1:0];
        else if (sh1 < X_MIN) xb = X_MIN[OUT_W-1:0];
        else                  xb = sh1[OUT_W-1:0];
`else
        xa = sh0[OUT_W-1:0];
        xb = sh1[OUT_W-1:0];
`endif
    end

`ifndef IDCT2_16_2_CLIP_EN
    // Wrap mode discards the high bits on purpose.
    logic unused_hi;
    assign unused_hi = ^{sh0[27:OUT_W], sh1[27:OUT_W]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        e_d     = e_q;
        x_d     = x_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    c_d     = C;
                    e_d     = E;
                    cnt_d   = 3'd0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                x_d[{1'b0, cnt_q}]         = xa;
                x_d[4'd15 - {1'b0, cnt_q}] = xb;
                cnt_d                      = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                c_q[i] <= '0;
                e_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            e_q     <= e_d;
            x_q     <= x_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_OUT);
    assign X         = x_q;
endmodule

// File: tb/tb_idct2_16_2.sv
module tb_idct2_16_2;
    localparam int OUT_W = 16;

    typedef int vec8_t [8];
    typedef int vec16_t [16];

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [15:0]      C [0:7];
    logic signed [25:0]      E [0:7];
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] X [0:15];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    idct2_16_2 #(.SHIFT(7), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .C         (C),
        .E         (E),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .X         (X)
    );

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_x(input string tag, input vec16_t ex);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_x%0d", tag, i), X[i], ex[i]);
        end
    endtask

    // Called on a negedge with the DUT idle; returns on the negedge where
    // out_valid should first be high. Inputs are scrambled after acceptance.
    task automatic run_vec(input string tag, input vec8_t c, input vec8_t e);
        for (int k = 0; k < 8; k++) begin
            C[k] = 16'(c[k]);
            E[k] = 26'(e[k]);
        end
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            C[k] = 16'($urandom);
            E[k] = 26'($urandom);
        end
        repeat (7) @(negedge clk);
        chk({tag, "_vld_early"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_vld"}, out_valid, 1);
    endtask

    // Full vector with out_ready high: check result, then back to idle.
    task automatic do_vec(input string tag, input vec8_t c, input vec8_t e,
                          input vec16_t ex);
        run_vec(tag, c, e);
        check_x(tag, ex);
        @(negedge clk);
        chk({tag, "_idle"}, in_ready, 1);
        chk({tag, "_vld_off"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec8_t  z8, cv, ev;
        vec16_t z16, ex;
        int     seen_vld;

        z8  = '{default: 0};
        z16 = '{default: 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            C[k] = '0;
            E[k] = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        check_x("rst", z16);

        // Release reset with in_valid already high: accept on the next edge.
        rst = 1'b0;
        cv = z8; cv[0] = 128;
        do_vec("c0", cv, z8,
               '{90, 87, 80, 70, 57, 43, 25, 9,
                 -9, -25, -43, -57, -70, -80, -87, -90});

        cv = z8; cv[1] = 128;
        do_vec("c1", cv, z8,
               '{87, 57, 9, -43, -80, -90, -70, -25,
                 25, 70, 90, 80, 43, -9, -57, -87});

        cv = z8; cv[3] = -128;
        do_vec("c3n", cv, z8,
               '{-70, 43, 87, -9, -90, -25, 80, 57,
                 -57, -80, 25, 90, 9, -87, -43, 70});

        cv = z8; cv[0] = 128; cv[7] = 128;
        do_vec("c07", cv, z8,
               '{99, 62, 123, 13, 127, -37, 112, -81,
                 81, -112, 37, -127, -13, -123, -62, -99});

        ev = '{default: 1280};
        do_vec("e1280", z8, ev, '{default: 10});

        ev = z8; ev[0] = 64;
        ex = z16; ex[0] = 1; ex[15] = 1;
        do_vec("e64", z8, ev, ex);

        ev = z8; ev[0] = -64;
        do_vec("em64", z8, ev, z16);

        ev = z8; ev[0] = (1 << 25) - 1;
        ex = z16;
`ifdef IDCT2_16_2_CLIP_EN
        ex[0] = 32767; ex[15] = 32767;
`endif
        do_vec("emax", z8, ev, ex);

        // Backpressure: hold out_ready low for 5 cycles, pulse in_valid.
        out_ready = 1'b0;
        cv = z8; cv[0] = 128;
        run_vec("stall", cv, z8);
        ex = '{90, 87, 80, 70, 57, 43, 25, 9,
               -9, -25, -43, -57, -70, -80, -87, -90};
        for (int n = 0; n < 5; n++) begin
            check_x($sformatf("stall%0d", n), ex);
            chk($sformatf("stall%0d_in_ready", n), in_ready, 0);
            chk($sformatf("stall%0d_vld", n), out_valid, 1);
            in_valid = (n == 2);
            if (n == 2) begin
                for (int k = 0; k < 8; k++) C[k] = 16'sd300;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stall_hold_vld", out_valid, 1);
        check_x("stall_hold", ex);
        @(negedge clk);
        chk("stall_rel_in_ready", in_ready, 1);
        chk("stall_rel_vld", out_valid, 0);

        // Immediate next accept; its result must not be the dropped vector.
        cv = z8; cv[1] = 128;
        do_vec("after", cv, z8,
               '{87, 57, 9, -43, -80, -90, -70, -25,
                 25, 70, 90, 80, 43, -9, -57, -87});

        // Reset at T+4 mid-CALC abandons the vector.
        cv = z8; cv[0] = 128;
        for (int k = 0; k < 8; k++) C[k] = 16'(cv[k]);
        in_valid = 1'b1;
        chk("mid_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_vld", out_valid, 0);
        check_x("mid_rst", z16);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_post_in_ready", in_ready, 1);
        seen_vld = 0;
        for (int n = 0; n < 12; n++) begin
            if (out_valid !== 1'b0) seen_vld++;
            @(negedge clk);
        end
        chk("mid_no_vld", seen_vld, 0);

        // Recovery after reset.
        do_vec("recov", z8, '{default: 1280}, '{default: 10});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/idct2_16_2.md
# idct2_16_2

Inverse counterpart of the 16-point DCT-II stage-2 even/odd decomposition. Takes the eight odd-indexed transform coefficients and the eight even-path partial results from the 8-point inverse stage. Rebuilds the odd partial sums O[j] one per cycle with the transposed 16-point odd matrix, recombines them by butterfly, then rounds and shifts. Outputs a 16-sample residual vector through a valid/ready handshake; sits at the tail of the inverse 1-D transform in the IDCT2 datapath.

## Interface
- SHIFT, 7: right-shift after butterfly, ≥1, with rounding offset 1<<(SHIFT-1)
- OUT_W, 16: output sample width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- C[0:7]  in  signed 16 each  odd coefficients, C[k] = coefficient index 2k+1
- E[0:7]  in  signed 26 each  even-path reconstructed values
- out_valid  out  1  X holds a complete vector
- out_ready  in  1  downstream accepts X
- X[0:15]  out  signed OUT_W each  reconstructed samples

## Operation
- Matrix rows r0..r7, where forward odd output k = Σj rk[j]·O[j]:
  - r0: 90 87 80 70 57 43 25 9
  - r1: 87 57 9 -43 -80 -90 -70 -25
  - r2: 80 9 -70 -87 -25 57 90 43
  - r3: 70 -43 -87 9 90 25 -80 -57
  - r4: 57 -80 -25 90 -9 -87 43 70
  - r5: 43 -90 57 25 -87 70 9 -80
  - r6: 25 -70 90 -80 43 9 -57 87
  - r7: 9 -25 43 -57 70 -80 87 -90
- Inverse: O[j] = Σk rk[j]·C[k], signed 26 bits, exact (|O| < 2^25).
- Constant products use shift-add only; no generic multipliers.
- Butterfly per j:
  - S0 = E[j] + O[j] and S1 = E[j] − O[j], signed 27 bits.
  - X[j] = (S0 + 2^(SHIFT−1)) >>> SHIFT.
  - X[15−j] = the same rounding applied to S1.
  - Arithmetic shift, so rounding is half toward +∞.
- C and E are latched into internal registers on acceptance; input ports are don't-care afterwards.
- FSM:
  - IDLE: in_ready=1. On in_valid, latch inputs, cnt←0, go to CALC.
  - CALC: compute column cnt, register X[cnt] and X[15−cnt], cnt←cnt+1. When cnt=7, go to OUT.
  - OUT: out_valid=1. X and out_valid hold stable until out_ready=1, then go to IDLE.
- in_ready is 1 only in IDLE; in_valid outside IDLE is ignored.
- Reset values: state IDLE, cnt 0, out_valid 0, in_ready 1, every X and every latched register 0.
- Reset mid-CALC or mid-OUT abandons the vector. out_valid drops the cycle after rst is sampled. No partial output.

## Timing
- Handshake at edge T (in_valid & in_ready) → CALC occupies cycles T+1..T+8 → out_valid=1 from T+9.
- Accept at T+9 if out_ready=1 → IDLE at T+10, next input accepted at T+10.
- Throughput: one vector per 10 cycles minimum.
- Output buffer is written only in CALC; X is stable throughout OUT.
- Critical path: latched C → 8-term constant adder tree → butterfly → round → clip → X register, all in one cycle.

## Configuration
- IDCT2_16_2_CLIP_EN defined: each rounded result saturates to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- Undefined: each rounded result is truncated to its low OUT_W bits (two's-complement wrap).

## Test plan
- After reset, hold rst 2 cycles → out_valid=0, in_ready=1, X all 0. Hold in_valid=1 with in_ready observed 1 → handshake on the first cycle after release.
- C[0]=128, other C=0, E=0 → at T+9:
  - X[0..7] = 90 87 80 70 57 43 25 9
  - X[8..15] = −9 −25 −43 −57 −70 −80 −87 −90
- C=0, all E=1280 → all X=10. Separately, E[0]=64 → X[0]=X[15]=1; E[0]=−64 → X[0]=X[15]=0.
- C=0, E[0]=2^25−1 → X[0]=X[15]=32767 with IDCT2_16_2_CLIP_EN; X[0]=X[15]=0 without it.
- out_ready low 5 cycles during OUT, with in_valid pulsed and C changed meanwhile:
  - X stays stable and in_ready stays 0.
  - The pulsed vector is dropped.
  - After out_ready goes high, the next accept happens one cycle later.
- rst asserted at T+4 mid-CALC → out_valid never rises for that vector; IDLE with in_ready=1 on the cycle after reset is released.
